// File: rtl/ps2_mouse_read_byte_if.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_mouse_read_byte_if
//  Purpose  : Bundles the serial mouse data line and the recovered-byte
//             outputs of the PS/2 byte receiver.
//  Signals  : io_mouse_data     - serial data line (idles high)
//             o_byte            - last successfully received data byte
//             o_is_byte_readed  - one-cycle strobe, o_byte just updated
//  Modports : master - drives the data line, observes the byte outputs
//             slave  - the receiver; samples the line, drives the outputs
//  Revision : 1.0 - initial release
// ============================================================================
interface ps2_mouse_read_byte_if;
    logic       io_mouse_data;
    logic [7:0] o_byte;
    logic       o_is_byte_readed;

    modport master (
        output io_mouse_data,
        input  o_byte,
        input  o_is_byte_readed
    );

    modport slave (
        input  io_mouse_data,
        output o_byte,
        output o_is_byte_readed
    );
endinterface
`default_nettype wire

// File: rtl/ps2_mouse_read_byte.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_mouse_read_byte
//  Purpose  : Receives one PS/2 frame (start 0, 8 data bits LSB first,
//             parity, stop 1), one bit per rising edge of i_driver_clk, and
//             presents the byte with a one-cycle ready strobe.
//  Ports    : i_driver_clk - sampling clock, one serial bit per rising edge
//             rst_n        - synchronous active-low reset
//             bus (slave)  - io_mouse_data in; o_byte, o_is_byte_readed out
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_mouse_read_byte (
    input  wire logic              i_driver_clk,
    input  wire logic              rst_n,
    ps2_mouse_read_byte_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t     r_state,   w_state_next;
    logic [2:0] r_bit_cnt, w_bit_cnt_next;
    logic [7:0] r_shift,   w_shift_next;
    logic [7:0] r_byte,    w_byte_next;
    logic       r_ready,   w_ready_next;

    // Next-state and datapath decode.
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_byte_next    = r_byte;
        w_ready_next   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A low sample in IDLE is a start bit, including one that
                // arrives directly after the previous stop bit.
                if (!bus.io_mouse_data) begin
                    w_state_next   = S_DATA;
                    w_bit_cnt_next = 3'd0;
                end
            end
            S_DATA: begin
                w_shift_next[r_bit_cnt] = bus.io_mouse_data;
                w_bit_cnt_next          = r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    w_state_next = S_PARITY;
                end
            end
            S_PARITY: begin
                // Parity is deliberately not checked, so the bit is consumed
                // without being stored.
                w_state_next = S_STOP;
            end
            S_STOP: begin
                // Only a valid high stop bit publishes the byte; a low stop
                // bit drops the frame and leaves o_byte untouched.
                if (bus.io_mouse_data) begin
                    w_byte_next  = r_shift;
                    w_ready_next = 1'b1;
                end
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_driver_clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_byte    <= 8'h00;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_byte    <= w_byte_next;
            r_ready   <= w_ready_next;
        end
    end

    assign bus.o_byte           = r_byte;
    assign bus.o_is_byte_readed = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_read_byte.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_mouse_read_byte
//  Purpose  : Self-checking bench for ps2_mouse_read_byte: directed vector
//             table, hand-written corner sequences and randomized traffic
//             against a frame-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_mouse_read_byte;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_mouse_read_byte_if bus_if ();

    ps2_mouse_read_byte dut (
        .i_driver_clk (clk),
        .rst_n        (rst_n),
        .bus          (bus_if)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         rst_n;
        bit         data;
        logic [7:0] exp_byte;
        bit         exp_strobe;
    } vec_t;

    vec_t vecs[$];

    // Reference model: collects the raw bits of a frame and decodes the
    // whole frame once all eleven bits have been seen.
    bit         m_active = 1'b0;
    int         m_n      = 0;
    bit         m_bits[11];
    logic [7:0] m_byte   = 8'h00;
    bit         m_strobe = 1'b0;

    function automatic void model_step(input bit r, input bit d);
        m_strobe = 1'b0;
        if (!r) begin
            m_active = 1'b0;
            m_n      = 0;
            m_byte   = 8'h00;
            return;
        end
        if (!m_active) begin
            if (!d) begin
                m_active  = 1'b1;
                m_bits[0] = 1'b0;
                m_n       = 1;
            end
        end else begin
            m_bits[m_n] = d;
            m_n++;
            if (m_n == 11) begin
                m_active = 1'b0;
                if (m_bits[10]) begin
                    for (int k = 0; k < 8; k++) m_byte[k] = m_bits[k + 1];
                    m_strobe = 1'b1;
                end
            end
        end
    endfunction

    function automatic void check(input string name, input logic [7:0] act,
                                  input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns after the
    // rising edge that consumed them.
    task automatic cycle(input bit r, input bit d);
        @(negedge clk);
        rst_n            = r;
        bus_if.io_mouse_data = d;
        @(posedge clk);
        model_step(r, d);
        #1;
    endtask

    task automatic add_vec(input bit r, input bit d, input logic [7:0] eb,
                           input bit es);
        vec_t v;
        v.rst_n = r; v.data = d; v.exp_byte = eb; v.exp_strobe = es;
        vecs.push_back(v);
    endtask

    task automatic add_frame(input logic [7:0] b, input bit par, input bit stop,
                             input logic [7:0] prev);
        add_vec(1'b1, 1'b0, prev, 1'b0);
        for (int i = 0; i < 8; i++) add_vec(1'b1, b[i], prev, 1'b0);
        add_vec(1'b1, par, prev, 1'b0);
        add_vec(1'b1, stop, stop ? b : prev, stop);
    endtask

    logic [7:0] frame_5a;

    initial begin
        bus_if.io_mouse_data = 1'b1;

        // Directed table: reset, idle, three back-to-back frames (second has
        // wrong parity), idle, framing error, then a good frame.
        for (int i = 0; i < 3; i++) add_vec(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 2; i++) add_vec(1'b1, 1'b1, 8'h00, 1'b0);
        add_frame(8'h24, 1'b1, 1'b1, 8'h00);
        add_frame(8'h01, 1'b1, 1'b1, 8'h24);
        add_frame(8'h03, 1'b1, 1'b1, 8'h01);
        for (int i = 0; i < 4; i++) add_vec(1'b1, 1'b1, 8'h03, 1'b0);
        add_frame(8'h3C, 1'b1, 1'b0, 8'h03);
        add_frame(8'hA5, 1'b1, 1'b1, 8'h03);
        add_vec(1'b1, 1'b1, 8'hA5, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst_n, vecs[i].data);
            check($sformatf("vec%0d_byte", i), bus_if.o_byte, vecs[i].exp_byte);
            check($sformatf("vec%0d_strobe", i), {7'd0, bus_if.o_is_byte_readed},
                  {7'd0, vecs[i].exp_strobe});
        end

        // Reset in the middle of a frame: start bit plus four data bits,
        // then reset. Nothing may be delivered and o_byte must clear.
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1);
            check("midrst_strobe", {7'd0, bus_if.o_is_byte_readed}, 8'h00);
        end
        cycle(1'b0, 1'b1);
        check("midrst_byte", bus_if.o_byte, 8'h00);
        check("midrst_strobe_rst", {7'd0, bus_if.o_is_byte_readed}, 8'h00);
        cycle(1'b1, 1'b1);
        check("midrst_idle_byte", bus_if.o_byte, 8'h00);

        // Full 8'h5A frame afterwards; only the stop edge strobes.
        frame_5a = 8'h5A;
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, (i < 8) ? frame_5a[i] : 1'b1);
            check("f5a_body_strobe", {7'd0, bus_if.o_is_byte_readed}, 8'h00);
            check("f5a_body_byte", bus_if.o_byte, 8'h00);
        end
        cycle(1'b1, 1'b1);
        check("f5a_byte", bus_if.o_byte, 8'h5A);
        check("f5a_strobe", {7'd0, bus_if.o_is_byte_readed}, 8'h01);
        cycle(1'b1, 1'b1);
        check("f5a_strobe_drop", {7'd0, bus_if.o_is_byte_readed}, 8'h00);
        check("f5a_hold", bus_if.o_byte, 8'h5A);

        // Randomized traffic with occasional resets, checked every cycle.
        for (int i = 0; i < 3000; i++) begin
            bit r, d;
            r = ($urandom_range(0, 299) != 0);
            d = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            cycle(r, d);
            check($sformatf("rnd%0d_byte", i), bus_if.o_byte, m_byte);
            check($sformatf("rnd%0d_strobe", i), {7'd0, bus_if.o_is_byte_readed},
                  {7'd0, m_strobe});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_mouse_read_byte.md
Name: ps2_mouse_read_byte

Overview:
- Receives one PS/2-style serial frame from the mouse data line and presents the recovered byte with a one-cycle "byte ready" strobe.
- Frame format: start bit (0), 8 data bits LSB first, parity bit, stop bit (1).
- One data bit is sampled per rising edge of the driver clock. The block sits beneath the mouse packet decoder, which assembles 3-byte mouse packets from successive bytes.

Parameters:
- None.

Ports:
- i_driver_clk  input  1  Sampling clock; one serial bit per rising edge.
- rst_n  input  1  Synchronous, active-low reset, sampled on the rising edge of i_driver_clk.
- io_mouse_data  input  1  Serial mouse data line; idles high. Used as input only.
- o_byte  output  8  Last successfully received data byte.
- o_is_byte_readed  output  1  One-cycle strobe: o_byte has just been updated.

Behaviour:
- All state updates occur on the rising edge of i_driver_clk. Upstream logic changes io_mouse_data on the falling edge.
- Reset (rst_n=0 at a rising edge):
  - FSM goes to IDLE; bit counter = 0; shift register = 0.
  - o_byte = 8'h00; o_is_byte_readed = 0.
  - Reset mid-frame aborts the frame; nothing is output.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: io_mouse_data sampled 0 -> go to DATA, clear bit counter. Sampled 1 -> stay in IDLE.
  - DATA: shift the sampled bit into bit position [counter] (LSB first); counter +1. After the 8th data bit -> PARITY.
  - PARITY: capture the sampled bit. Parity is NOT checked; the byte is delivered regardless of parity value. Go to STOP.
  - STOP:
    - Sampled 1 -> load o_byte with the assembled byte, assert o_is_byte_readed, go to IDLE.
    - Sampled 0 -> framing error: discard the byte, o_byte unchanged, no strobe, go to IDLE.
- Output timing:
  - o_byte and o_is_byte_readed are registered at the edge that samples the stop bit.
  - Both are visible from that edge until the next rising edge; o_is_byte_readed is high for exactly one cycle.
- o_byte holds its value between frames and after a framing error.
- Latency: 11 rising edges from the start-bit sample edge to the output edge, inclusive.
- Back-to-back frames: a start bit immediately following a stop bit, with no idle cycle, is accepted. The cycle after STOP is IDLE and samples the new start bit.
- io_mouse_data is treated as already synchronous to i_driver_clk; no internal synchronizer.
- The data line held low while in IDLE after a frame is seen as a new start bit. This is intended behaviour.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with data=1 -> o_byte=8'h00, o_is_byte_readed=0, FSM stays IDLE after release while data=1.
- Frame 1: bits 0 | 0,0,1,0,0,1,0,0 | parity 1 | stop 1 -> o_byte=8'h24, o_is_byte_readed high for exactly one cycle at the stop-sample edge.
- Frame 2, back-to-back, wrong parity ignored: 0 | 1,0,0,0,0,0,0,0 | 1 | 1 -> o_byte=8'h01, single strobe.
- Frame 3, back-to-back: 0 | 1,1,0,0,0,0,0,0 | 1 | 1 -> o_byte=8'h03, single strobe; then data=1 idle for 4 cycles -> no further strobes, o_byte stays 8'h03.
- Framing error: valid frame with stop bit 0 -> no strobe, o_byte keeps its previous value (8'h03), next valid frame 8'hA5 is received correctly.
- Reset mid-frame: assert rst_n=0 after 4 data bits -> no strobe, o_byte=8'h00; a subsequent full frame 8'h5A -> o_byte=8'h5A.
